// File: rtl/aidc_lite_ahb_mem_slave.sv
// AHB-Lite slave backed by a 2**DEPTH_LOG2 x 32-bit word memory with byte/half/word writes.
// Latency: WAIT_STATES+1 data-phase cycles for OKAY transfers, always 2 cycles for ERROR.
// Backpressure: hreadyout low during wait states and the first ERROR cycle; no transfer accepted then.
module aidc_lite_ahb_mem_slave #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int AW = DEPTH_LOG2 + 2;
  localparam logic [1:0] WS_M1 = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t                state;
  logic [AW-1:0]         addr_q;
  logic                  write_q;
  logic [2:0]            size_q;
  logic [1:0]            wait_cnt;

  logic [31:0]           mem [0:2**DEPTH_LOG2-1];

  logic                  accept;
  logic                  legal;
  logic                  aligned;
  logic                  in_range;
  logic                  commit;
  logic [3:0]            be_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [DEPTH_LOG2-1:0] idx_in;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [31:0]           wr_word;
  logic [31:0]           rd_word;

  // Burst type and the BUSY/IDLE distinction carry no meaning here: each beat stands alone.
  logic unused_ok;
  assign unused_ok = ^{htrans[0], hburst};

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
    case (size)
      3'd0:    lane_mask = 4'b0001 << a;
      3'd1:    lane_mask = a[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // New transfers are only taken when no data phase is stalled or erroring.
  assign accept   = hsel && hready && htrans[1] && ((state == S_IDLE) || (state == S_DATA));
  assign in_range = (haddr[31:AW] == '0);
  assign legal    = (hsize <= 3'd2) && aligned && in_range;
  assign idx_q    = addr_q[AW-1:2];
  assign idx_in   = haddr[AW-1:2];
  assign commit   = (state == S_DATA) && write_q;
  assign be_q     = lane_mask(size_q, addr_q[1:0]);

  // Alignment check on the address-phase size/address pair.
  always_comb begin
    aligned = 1'b1;
    case (hsize)
      3'd1:    aligned = ~haddr[0];
      3'd2:    aligned = (haddr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  // Merged word of the write committing this cycle, used to forward into a read that
  // enters its data phase at the same edge (zero-wait back-to-back write then read).
  always_comb begin
    wr_word = mem[idx_q];
    for (int b = 0; b < 4; b++) begin
      if (be_q[b]) wr_word[8*b +: 8] = hwdata[8*b +: 8];
    end
  end

  // Read source: the latched address when leaving WAIT, otherwise the address on the bus.
  always_comb begin
    rd_idx  = (state == S_WAIT) ? idx_q : idx_in;
    rd_word = (commit && (rd_idx == idx_q)) ? wr_word : mem[rd_idx];
  end

  // Transfer FSM with registered hreadyout/hresp/hrdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      hrdata    <= '0;
      wait_cnt  <= 2'd0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      size_q    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DATA: begin
          if (accept) begin
            addr_q  <= haddr[AW-1:0];
            write_q <= hwrite;
            size_q  <= hsize;
            if (!legal) begin
              state     <= S_ERR1;
              hreadyout <= 1'b0;
              hresp     <= 1'b1;
              hrdata    <= '0;
            end else if (WAIT_STATES > 0) begin
              state     <= S_WAIT;
              wait_cnt  <= WS_M1;
              hreadyout <= 1'b0;
              hresp     <= 1'b0;
              hrdata    <= '0;
            end else begin
              state     <= S_DATA;
              hreadyout <= 1'b1;
              hresp     <= 1'b0;
              hrdata    <= hwrite ? 32'h0 : rd_word;
            end
          end else begin
            state     <= S_IDLE;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            hrdata    <= '0;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 2'd0) begin
            state     <= S_DATA;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            hrdata    <= write_q ? 32'h0 : rd_word;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        S_ERR1: begin
          state     <= S_ERR2;
          hreadyout <= 1'b1;
          hresp     <= 1'b1;
          hrdata    <= '0;
        end
        S_ERR2: begin
          state     <= S_IDLE;
          hreadyout <= 1'b1;
          hresp     <= 1'b0;
          hrdata    <= '0;
        end
        default: begin
          state     <= S_IDLE;
          hreadyout <= 1'b1;
          hresp     <= 1'b0;
          hrdata    <= '0;
        end
      endcase
    end
  end

  // Byte-lane write at the end of a write DATA cycle; reset aborts it, contents are never cleared.
  always_ff @(posedge clk) begin
    if (!rst && commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_aidc_lite_ahb_mem_slave.sv
// Directed bench for aidc_lite_ahb_mem_slave: three instances (1, 0 and 2 wait states) share one bus.
// Expected responses are queued when a transfer is driven and checked when its data phase completes.
// Bus hready follows the selected instance's hreadyout, as in a single-slave system.
module tb_aidc_lite_ahb_mem_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic [1:0]  sel;

  logic        ro [3];
  logic        rs [3];
  logic [31:0] rd [3];
  logic        bus_ro;
  logic        bus_rs;
  logic [31:0] bus_rd;

  always #5 clk = ~clk;

  always_comb begin
    bus_ro = ro[sel];
    bus_rs = rs[sel];
    bus_rd = rd[sel];
  end
  assign hready = bus_ro;

  aidc_lite_ahb_mem_slave #(.DEPTH_LOG2(10), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst), .hsel(hsel && (sel == 2'd0)), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hready),
    .hreadyout(ro[0]), .hresp(rs[0]), .hrdata(rd[0]));

  aidc_lite_ahb_mem_slave #(.DEPTH_LOG2(10), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .hsel(hsel && (sel == 2'd1)), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hready),
    .hreadyout(ro[1]), .hresp(rs[1]), .hrdata(rd[1]));

  aidc_lite_ahb_mem_slave #(.DEPTH_LOG2(10), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst(rst), .hsel(hsel && (sel == 2'd2)), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hready),
    .hreadyout(ro[2]), .hresp(rs[2]), .hrdata(rd[2]));

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          cycles;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] rdata, input logic err, input int cyc);
    exp_t e;
    e.tag = tag; e.rdata = rdata; e.err = err; e.cycles = cyc;
    sb.push_back(e);
  endtask

  task automatic idle_bus();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] a, input logic [2:0] sz, input logic [1:0] tr);
    hsel = 1'b1; htrans = tr; hwrite = wr; haddr = a; hsize = sz;
  endtask

  // Count data-phase cycles (bounded) and note the response of the first one.
  task automatic data_phase(output int n, output logic first_resp);
    n = 1;
    first_resp = bus_rs;
    while (!bus_ro && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic complete(input int n, input logic first_resp);
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_cycles"}, 32'(n), 32'(e.cycles));
      chk({e.tag, "_resp_first"}, {31'd0, first_resp}, {31'd0, e.err});
      chk({e.tag, "_resp_last"}, {31'd0, bus_rs}, {31'd0, e.err});
      chk({e.tag, "_rdata"}, bus_rd, e.rdata);
    end
  endtask

  // Single non-pipelined transfer.
  task automatic xfer(input string tag, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wdata, input logic [31:0] exp_rd, input logic err, input int cyc);
    int   n;
    logic fr;
    @(negedge clk);
    addr_phase(wr, a, sz, 2'b10);
    push(tag, exp_rd, err, cyc);
    @(negedge clk);
    idle_bus();
    hwdata = wdata;
    data_phase(n, fr);
    complete(n, fr);
  endtask

  // Word write immediately followed by a read of the same word during the write's data phase.
  task automatic pipe_wr_rd(input string tag, input logic [31:0] a, input logic [31:0] wdata, input int cyc);
    int   n;
    logic fr;
    @(negedge clk);
    addr_phase(1'b1, a, 3'd2, 2'b10);
    push({tag, "_wr"}, 32'h0, 1'b0, cyc);
    @(negedge clk);
    hwdata = wdata;
    addr_phase(1'b0, a, 3'd2, 2'b10);
    data_phase(n, fr);
    complete(n, fr);
    push({tag, "_rd"}, wdata, 1'b0, cyc);
    @(negedge clk);
    idle_bus();
    data_phase(n, fr);
    complete(n, fr);
  endtask

  initial begin
    int   n;
    logic fr;
    logic [31:0] bw [4];

    rst = 1'b1; sel = 2'd0; hburst = 3'b000; haddr = '0; hsize = 3'd2; hwdata = '0;
    idle_bus();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_hreadyout_%0d", k), {31'd0, ro[k]}, 32'd1);
      chk($sformatf("reset_hresp_%0d", k), {31'd0, rs[k]}, 32'd0);
      chk($sformatf("reset_hrdata_%0d", k), rd[k], 32'd0);
    end
    rst = 1'b0;

    // One wait state: word, byte and half accesses.
    xfer("w_deadbeef", 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    xfer("r_deadbeef", 1'b0, 32'h10, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    xfer("w_base", 1'b1, 32'h10, 3'd2, 32'h11223344, 32'h0, 1'b0, 2);
    xfer("w_byte13", 1'b1, 32'h13, 3'd0, 32'hAAEEEEEE, 32'h0, 1'b0, 2);
    xfer("r_byte13", 1'b0, 32'h10, 3'd2, 32'h0, 32'hAA223344, 1'b0, 2);
    xfer("w_half10", 1'b1, 32'h10, 3'd1, 32'hEEEE5566, 32'h0, 1'b0, 2);
    xfer("r_half10", 1'b0, 32'h10, 3'd2, 32'h0, 32'hAA225566, 1'b0, 2);
    xfer("w_byte11", 1'b1, 32'h11, 3'd0, 32'hEEEE77EE, 32'h0, 1'b0, 2);
    xfer("r_byte11", 1'b0, 32'h12, 3'd1, 32'h0, 32'hAA227766, 1'b0, 2);
    pipe_wr_rd("pipe_ws1", 32'h14, 32'h600DCAFE, 2);

    // Address window edges and illegal transfers.
    xfer("w_word0", 1'b1, 32'h0, 3'd2, 32'h0BADF00D, 32'h0, 1'b0, 2);
    xfer("w_lastword", 1'b1, 32'hFFC, 3'd2, 32'h5A5AA5A5, 32'h0, 1'b0, 2);
    xfer("r_lastword", 1'b0, 32'hFFC, 3'd2, 32'h0, 32'h5A5AA5A5, 1'b0, 2);
    xfer("w_oob", 1'b1, 32'h1000, 3'd2, 32'hFFFFFFFF, 32'h0, 1'b1, 2);
    xfer("w_misaligned_word", 1'b1, 32'h02, 3'd2, 32'hFFFFFFFF, 32'h0, 1'b1, 2);
    xfer("r_misaligned_half", 1'b0, 32'h01, 3'd1, 32'h0, 32'h0, 1'b1, 2);
    xfer("r_size3", 1'b0, 32'h0, 3'd3, 32'h0, 32'h0, 1'b1, 2);
    xfer("r_oob", 1'b0, 32'h1000, 3'd2, 32'h0, 32'h0, 1'b1, 2);
    xfer("r_word0_intact", 1'b0, 32'h0, 3'd2, 32'h0, 32'h0BADF00D, 1'b0, 2);

    // A transfer presented in the second ERROR cycle is dropped.
    @(negedge clk);
    addr_phase(1'b1, 32'h1000, 3'd2, 2'b10);
    @(negedge clk);
    idle_bus();
    chk("err1_hreadyout", {31'd0, bus_ro}, 32'd0);
    chk("err1_hresp", {31'd0, bus_rs}, 32'd1);
    @(negedge clk);
    chk("err2_hreadyout", {31'd0, bus_ro}, 32'd1);
    chk("err2_hresp", {31'd0, bus_rs}, 32'd1);
    addr_phase(1'b1, 32'h0, 3'd2, 2'b10);
    hwdata = 32'hFFFFFFFF;
    @(negedge clk);
    idle_bus();
    chk("after_err2_hreadyout", {31'd0, bus_ro}, 32'd1);
    chk("after_err2_hresp", {31'd0, bus_rs}, 32'd0);
    @(negedge clk);
    xfer("r_word0_after_err2", 1'b0, 32'h0, 3'd2, 32'h0, 32'h0BADF00D, 1'b0, 2);

    // Reset during a write's wait state aborts it; transfers under reset are ignored.
    xfer("w_prior40", 1'b1, 32'h40, 3'd2, 32'h12345678, 32'h0, 1'b0, 2);
    @(negedge clk);
    addr_phase(1'b1, 32'h40, 3'd2, 2'b10);
    @(negedge clk);
    idle_bus();
    hwdata = 32'hCAFEF00D;
    chk("rst_wait_hreadyout", {31'd0, bus_ro}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_abort_hreadyout", {31'd0, bus_ro}, 32'd1);
    chk("rst_abort_hresp", {31'd0, bus_rs}, 32'd0);
    chk("rst_abort_hrdata", bus_rd, 32'd0);
    addr_phase(1'b1, 32'h40, 3'd2, 2'b10);
    @(negedge clk);
    rst = 1'b0;
    idle_bus();
    chk("rst_ignored_xfer_hreadyout", {31'd0, bus_ro}, 32'd1);
    @(negedge clk);
    chk("rst_ignored_xfer_idle", {31'd0, bus_ro}, 32'd1);
    xfer("r_prior40", 1'b0, 32'h40, 3'd2, 32'h0, 32'h12345678, 1'b0, 2);

    // Zero wait states: back-to-back write/read with forwarding, and the fixed 2-cycle ERROR.
    @(negedge clk);
    sel = 2'd1;
    pipe_wr_rd("pipe_ws0", 32'h20, 32'h00000001, 1);
    xfer("ws0_w_oob", 1'b1, 32'h1000, 3'd2, 32'h0, 32'h0, 1'b1, 2);
    xfer("ws0_r_20", 1'b0, 32'h20, 3'd2, 32'h0, 32'h00000001, 1'b0, 1);

    // Two wait states: fill four words, then a 4-beat INCR read burst.
    @(negedge clk);
    sel = 2'd2;
    for (int i = 0; i < 4; i++) begin
      bw[i] = 32'hB0000000 + 32'(i) * 32'h01010101;
      xfer($sformatf("ws2_w%0d", i), 1'b1, 32'(4 * i), 3'd2, bw[i], 32'h0, 1'b0, 3);
    end
    @(negedge clk);
    hburst = 3'b011;
    addr_phase(1'b0, 32'h0, 3'd2, 2'b10);
    push("burst0", bw[0], 1'b0, 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) begin
        addr_phase(1'b0, 32'(4 * (i + 1)), 3'd2, 2'b11);
        push($sformatf("burst%0d", i + 1), bw[i + 1], 1'b0, 3);
      end else begin
        idle_bus();
      end
      data_phase(n, fr);
      complete(n, fr);
    end
    hburst = 3'b000;
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/aidc_lite_ahb_mem_slave.md
AIDC_LITE_AHB_MEM_SLAVE -- requirements
Module: aidc_lite_ahb_mem_slave

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, SHALL set word count to 2**DEPTH_LOG2 (32-bit words; 4 KB at default).
REQ-002 Parameter WAIT_STATES, default 1, range 0..3, SHALL set wait cycles inserted per OKAY data phase.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 hsel  input  1  slave select.
REQ-006 haddr  input  32  byte address; window is 0 .. 4*2**DEPTH_LOG2-1.
REQ-007 htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-008 hwrite  input  1  1=write, 0=read.
REQ-009 hsize  input  3  0=byte, 1=half, 2=word; 3..7 unsupported.
REQ-010 hburst  input  3  accepted, ignored (each beat handled independently).
REQ-011 hwdata  input  32  write data, sampled in data phase.
REQ-012 hready  input  1  bus-level ready (address phase qualifier).
REQ-013 hreadyout  output  1  slave ready; low extends current data phase.
REQ-014 hresp  output  1  0=OKAY, 1=ERROR.
REQ-015 hrdata  output  32  read data, valid when hreadyout=1 in a read data phase.

Function
REQ-016 Transfer SHALL be accepted when hsel=1, hready=1 and htrans[1]=1; haddr, hwrite, hsize latched into addr_q/write_q/size_q at that edge.
REQ-017 hsel=1 with IDLE/BUSY, or hsel=0, SHALL leave the slave with no pending data phase (zero-wait OKAY).
REQ-018 FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
REQ-019 IDLE: hreadyout=1, hresp=0; accepted legal transfer -> WAIT if WAIT_STATES>0 else DATA; accepted illegal transfer -> ERR1.
REQ-020 WAIT: hreadyout=0, hresp=0; 2-bit counter loaded with WAIT_STATES-1 on entry, decrements each cycle; at 0 -> DATA.
REQ-021 DATA: hreadyout=1, hresp=0; write commits at this cycle's edge; new accepted transfer -> WAIT/DATA/ERR1 (pipelined back-to-back), else IDLE.
REQ-022 Illegal transfer: hsize>2, or misaligned (hsize=1 and haddr[0]=1; hsize=2 and haddr[1:0]!=0), or haddr >= 4*2**DEPTH_LOG2.
REQ-023 ERR1: hreadyout=0, hresp=1; -> ERR2 unconditionally.
REQ-024 ERR2: hreadyout=1, hresp=1; transfers presented here SHALL be ignored (master cancels per AHB); -> IDLE.
REQ-025 Errored writes SHALL NOT modify memory; errored reads SHALL drive hrdata=0.
REQ-026 Write byte lanes: byte -> lane haddr[1:0]; half -> lanes {haddr[1],0}+{0,1}; word -> all four; other lanes unchanged.
REQ-027 Word index SHALL be addr_q[DEPTH_LOG2+1:2].
REQ-028 hrdata SHALL be the full 32-bit word mem[index] in read DATA cycles, 0 otherwise; no lane masking.
REQ-029 Read accepted in the DATA cycle of a write to the same word SHALL return the newly written data (write commits before read data phase).
REQ-030 Total data-phase latency SHALL be WAIT_STATES+1 cycles for OKAY, exactly 2 for ERROR.
REQ-031 hreadyout SHALL never be low for more than max(WAIT_STATES,1) consecutive cycles.

Reset
REQ-032 rst=1 SHALL force IDLE, hreadyout=1, hresp=0, hrdata=0, wait counter=0, latched phase registers cleared.
REQ-033 Reset mid data phase SHALL abort it; a pending write SHALL NOT commit.
REQ-034 Memory array SHALL NOT be reset; contents survive rst.
REQ-035 Transfers presented while rst=1 SHALL be ignored.

Verification
REQ-036 WAIT_STATES=1: word write 0xDEADBEEF @0x10, then read @0x10 -> hreadyout low 1 cycle each phase, hrdata=0xDEADBEEF, hresp=0.
REQ-037 Byte write 0xAA @0x13 onto word 0x11223344 @0x10 -> read returns 0xAA223344; half write 0x5566 @0x10 -> 0xAA225566.
REQ-038 WAIT_STATES=0: back-to-back write 0x1 @0x20, read @0x20 -> read data phase returns 0x00000001, no stall.
REQ-039 Write @0x1000 (DEPTH_LOG2=10) -> hreadyout 0/hresp 1, then hreadyout 1/hresp 1; word @0x0 unchanged; also hsize=2 @0x02 -> same 2-cycle ERROR.
REQ-040 rst asserted during WAIT of write 0xCAFEF00D @0x40 -> next cycle hreadyout=1, hresp=0; read @0x40 returns prior value.
REQ-041 4-beat INCR read burst 0x00..0x0C, WAIT_STATES=2 -> each beat 3-cycle data phase, correct words in order, no ERROR.
